// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg
// Shared types and widths for the fifo_stream receive path.
//   WORD_W / BEAT_W / BEATS : input word width, output beat width, beats per word
//   rx_state_t              : serialiser states
//   entry_t                 : one buffer entry (word plus end-of-burst bit)
package fifo_stream_pkg;

  localparam int WORD_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              last;
  } entry_t;

endpackage

// File: rtl/fifo_stream_rx_buf.sv
// fifo_stream_rx_buf
// DEPTH-entry word store for fifo_stream_rx.
// Ports:
//   clk       : clock
//   wr_en     : store wr_entry at wr_addr
//   tag_en    : set the last bit of entry tag_addr (never coincides with wr_en)
//   rd_en     : registered read of entry rd_addr, result on rd_entry next cycle
//   rd_entry  : read data and last bit
// Word data sits in an inferred RAM; the last bits live in flops so they can
// be tagged after the word was written without a second RAM write port.
module fifo_stream_rx_buf
  import fifo_stream_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  entry_t                   wr_entry,
  input  logic                     tag_en,
  input  logic [$clog2(DEPTH)-1:0] tag_addr,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output entry_t                   rd_entry
);

  localparam int PW = $clog2(DEPTH);

  logic [WORD_W-1:0] data_mem [DEPTH];
  logic              last_q   [DEPTH];
  logic [WORD_W-1:0] rd_data_q;
  logic              rd_last_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_addr] <= wr_entry.data;
    end
    if (rd_en) begin
      rd_data_q <= data_mem[rd_addr];
      rd_last_q <= last_q[rd_addr];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_last
      always_ff @(posedge clk) begin
        if (wr_en && wr_addr == PW'(gi)) begin
          last_q[gi] <= wr_entry.last;
        end else if (tag_en && tag_addr == PW'(gi)) begin
          last_q[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign rd_entry = '{data: rd_data_q, last: rd_last_q};

endmodule

// File: rtl/fifo_stream_rx.sv
// fifo_stream_rx
// Receives 256-bit words from the DDR2 readout (no backpressure), buffers
// them and serialises each into four 64-bit beats on a valid/ready stream.
// Ports:
//   clk_clk, reset_reset_n        : clock, synchronous active-low reset
//   fifo_data/fifo_write          : incoming word, dropped only when full
//   fifo_send                     : end-of-burst tag (with a write, or alone
//                                   to tag the most recent word)
//   out_data/out_valid/out_ready  : beat stream, bits [63:0] first
//   out_last                      : beat 3 of a tagged word
//   level                         : entries in the buffer (not the holding reg)
//   overflow, orphan_send         : sticky error flags, cleared by flag_clr
// Optional: define FIFO_STREAM_RX_STATS_EN to add word_cnt / burst_cnt.
module fifo_stream_rx
  import fifo_stream_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [WORD_W-1:0]      fifo_data,
  input  logic                   fifo_write,
  input  logic                   fifo_send,
  output logic [BEAT_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   orphan_send,
  input  logic                   flag_clr
`ifdef FIFO_STREAM_RX_STATS_EN
  ,
  output logic [CNT_W-1:0]       word_cnt,
  output logic [CNT_W-1:0]       burst_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  rx_state_t         state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [1:0]        beat_q, beat_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_last_q, hold_last_d;
  logic              tag_fwd_q, tag_fwd_d;
  logic              overflow_q, overflow_d;
  logic              orphan_q, orphan_d;

  logic   full, wr_acc, accept, word_done, rd_issue;
  logic   send_alone, tag_buf, tag_hold, orphan_set;
  entry_t wr_entry, rd_entry;

  // Fullness is judged on the registered level, before this cycle's pop.
  assign full       = (level_q == LW'(DEPTH));
  assign wr_acc     = fifo_write && !full;
  assign accept     = (state_q == SHIFT) && out_ready;
  assign word_done  = accept && (beat_q == 2'd3);
  assign rd_issue   = (level_q != '0) && ((state_q == EMPTY) || word_done);

  // A lone send targets the newest word: the buffer tail if anything is
  // buffered, else the holding reg while its final beat is still pending.
  assign send_alone = fifo_send && !fifo_write;
  assign tag_buf    = send_alone && (level_q != '0);
  assign tag_hold   = send_alone && (level_q == '0) &&
                      ((state_q == LOAD) || ((state_q == SHIFT) && !word_done));
  assign orphan_set = send_alone && !tag_buf && !tag_hold;

  assign wr_entry = '{data: fifo_data, last: fifo_send};

  fifo_stream_rx_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk      (clk_clk),
    .wr_en    (wr_acc),
    .wr_addr  (wr_ptr_q),
    .wr_entry (wr_entry),
    .tag_en   (tag_buf),
    .tag_addr (wr_ptr_q - PW'(1)),
    .rd_en    (rd_issue),
    .rd_addr  (rd_ptr_q),
    .rd_entry (rd_entry)
  );

  // State register
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (level_q != '0) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (word_done) state_d = (level_q != '0) ? LOAD : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Outputs: beat select is beat*64, formed by appending six zero bits.
  always_comb begin
    out_valid = (state_q == SHIFT);
    out_last  = (state_q == SHIFT) && (beat_q == 2'd3) && hold_last_q;
    out_data  = hold_q[{beat_q, 6'd0} +: BEAT_W];
  end

  // Datapath next-state
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    beat_d      = beat_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    tag_fwd_d   = 1'b0;
    overflow_d  = flag_clr ? 1'b0 : overflow_q;
    orphan_d    = flag_clr ? 1'b0 : orphan_q;

    if (wr_acc)   wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_issue) rd_ptr_d = rd_ptr_q + PW'(1);
    if (wr_acc && !rd_issue)      level_d = level_q + LW'(1);
    else if (!wr_acc && rd_issue) level_d = level_q - LW'(1);

    if (fifo_write && full) overflow_d = 1'b1;
    if (orphan_set)         orphan_d   = 1'b1;

    // Tag written to the entry being read this same cycle: the registered
    // read returns the old last bit, so carry the tag into LOAD.
    if (tag_buf && rd_issue && (level_q == LW'(1))) tag_fwd_d = 1'b1;

    case (state_q)
      LOAD: begin
        hold_d      = rd_entry.data;
        hold_last_d = rd_entry.last | tag_fwd_q | tag_hold;
        beat_d      = 2'd0;
      end
      SHIFT: begin
        if (accept && (beat_q != 2'd3)) beat_d = beat_q + 2'd1;
        if (tag_hold) hold_last_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      beat_q      <= '0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      tag_fwd_q   <= 1'b0;
      overflow_q  <= 1'b0;
      orphan_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      beat_q      <= beat_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      tag_fwd_q   <= tag_fwd_d;
      overflow_q  <= overflow_d;
      orphan_q    <= orphan_d;
    end
  end

  assign level       = level_q;
  assign overflow    = overflow_q;
  assign orphan_send = orphan_q;

`ifdef FIFO_STREAM_RX_STATS_EN
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d, burst_cnt_q, burst_cnt_d;

  always_comb begin
    word_cnt_d  = word_cnt_q + CNT_W'(wr_acc);
    burst_cnt_d = burst_cnt_q + CNT_W'(accept && out_last);
    if (flag_clr) begin
      word_cnt_d  = '0;
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      word_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign word_cnt  = word_cnt_q;
  assign burst_cnt = burst_cnt_q;
`endif

endmodule
